// File: rtl/opti_pkg.sv
// Shared definitions for the IIR SOS cascade input side: feeder state encodings and data defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   OPTI_DATA_W      default sample width (Q1.15 two's complement)
//   OPTI_STABLE_LEN  default stable-window length, shared with the pipeline controller
//   ENC_*            3-bit state encodings of the sample feeder
//   feeder_state_t   feeder FSM state type built on the encodings above
//   gap_load_val()   timer reload value that yields exactly 'gap' idle cycles
package opti_pkg;

    localparam int OPTI_DATA_W     = 16;
    localparam int OPTI_STABLE_LEN = 237;

    localparam logic [2:0] ENC_IDLE    = 3'd0;
    localparam logic [2:0] ENC_FETCH   = 3'd1;
    localparam logic [2:0] ENC_WAIT    = 3'd2;
    localparam logic [2:0] ENC_PRESENT = 3'd3;
    localparam logic [2:0] ENC_GAP     = 3'd4;
    localparam logic [2:0] ENC_FLUSH   = 3'd5;
    localparam logic [2:0] ENC_DRAIN   = 3'd6;
    localparam logic [2:0] ENC_DONE    = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = ENC_IDLE,
        S_FETCH   = ENC_FETCH,
        S_WAIT    = ENC_WAIT,
        S_PRESENT = ENC_PRESENT,
        S_GAP     = ENC_GAP,
        S_FLUSH   = ENC_FLUSH,
        S_DRAIN   = ENC_DRAIN,
        S_DONE    = ENC_DONE
    } feeder_state_t;

    // The timer reports 'expired' while it holds zero, and the GAP state is
    // entered on the edge that loads it, so loading gap-1 gives gap cycles.
    function automatic logic [7:0] gap_load_val(input int gap);
        if (gap > 0) begin
            return 8'(gap - 1);
        end
        return 8'd0;
    endfunction

endpackage

// File: rtl/opti_gap_timer.sv
// Loadable 8-bit down-counter spacing samples (GAP and FLUSH spacing of the sample feeder).
// Latency: load takes effect on the next clk edge; expired is combinational from the count.
// Backpressure: none; counts down freely to zero and parks there until reloaded.
//
// Ports:
//   clk       clock, all logic on posedge
//   rst       asynchronous active-high reset (count cleared, expired high)
//   load      load load_val on the next edge (has priority over counting)
//   load_val  reload value
//   expired   high while the count is zero
module opti_gap_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       expired
);

    logic [7:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign expired = (cnt == 8'd0);

endmodule

// File: rtl/opti_sample_feeder.sv
// Streams NUM_SAMPLES samples from a sync-read RAM into SOS stage 1, optionally zero-flushes, then waits for filter_done.
// Latency: first data_in_valid 3 cycles after start is sampled; 1 sample per 3+GAP_CYCLES cycles.
// Backpressure: data_in/data_in_valid hold until data_in_ready; ready low stalls indefinitely.
//
// Optional feature macro: OPTI_FEEDER_FLUSH_EN -- when defined, FLUSH_LEN zero samples follow the
// last RAM sample (same GAP spacing). When undefined the FLUSH state and its counter are absent.
//
// Ports:
//   clk, rst                  clock / asynchronous active-high reset
//   start                     run request, honoured only when idle or done
//   mem_rd_en, mem_addr       RAM read strobe and address (address = current sample index)
//   mem_rd_data               RAM data, valid one cycle after mem_rd_en
//   data_in, data_in_valid    sample to SOS stage 1
//   data_in_ready             SOS stage 1 accepts
//   filter_done               pipeline controller reports the run complete (only seen in DRAIN)
//   busy, feed_done           running / finished status
//   sample_cnt                RAM samples accepted this run (flush samples not counted)
module opti_sample_feeder
    import opti_pkg::*;
#(
    parameter int DATA_W      = OPTI_DATA_W,
    parameter int ADDR_W      = 11,
    parameter int NUM_SAMPLES = 2048,
    parameter int GAP_CYCLES  = 0,
    parameter int FLUSH_LEN   = OPTI_STABLE_LEN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic [DATA_W-1:0] data_in,
    output logic              data_in_valid,
    input  logic              data_in_ready,
    input  logic              filter_done,
    output logic              busy,
    output logic              feed_done,
    output logic [ADDR_W:0]   sample_cnt
);

    // Elaboration-time range checks on the configuration.
    if (NUM_SAMPLES < 1 || NUM_SAMPLES > (1 << ADDR_W)) begin : g_bad_num_samples
        $error("opti_sample_feeder: NUM_SAMPLES outside 1..2**ADDR_W");
    end
    if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
        $error("opti_sample_feeder: GAP_CYCLES outside 0..255");
    end
    if (FLUSH_LEN < 1 || FLUSH_LEN > 1023) begin : g_bad_flush_len
        $error("opti_sample_feeder: FLUSH_LEN outside 1..1023");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_SAMPLES - 1);
    localparam logic [7:0]        GAP_LOAD = gap_load_val(GAP_CYCLES);
    localparam bit                HAS_GAP  = (GAP_CYCLES > 0);

    feeder_state_t     state;
    logic [ADDR_W-1:0] idx;
    logic              xfer;
    logic              gap_load;
    logic              gap_expired;

`ifdef OPTI_FEEDER_FLUSH_EN
    localparam logic [9:0] FLUSH_LAST = 10'(FLUSH_LEN - 1);
    logic [9:0] flush_cnt;
    // Set once the last RAM sample is accepted: GAP then returns to FLUSH, not FETCH.
    logic       flushing;
`endif

    assign xfer     = data_in_valid & data_in_ready;
    assign mem_addr = idx;

    // Reload on every accepted sample; the timer is only consulted in GAP.
    assign gap_load = HAS_GAP && xfer && ((state == S_PRESENT) || (state == S_FLUSH));

    opti_gap_timer u_gap_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (gap_load),
        .load_val (GAP_LOAD),
        .expired  (gap_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            idx           <= '0;
            mem_rd_en     <= 1'b0;
            data_in       <= '0;
            data_in_valid <= 1'b0;
            busy          <= 1'b0;
            feed_done     <= 1'b0;
            sample_cnt    <= '0;
`ifdef OPTI_FEEDER_FLUSH_EN
            flush_cnt     <= 10'd0;
            flushing      <= 1'b0;
`endif
        end else begin
            // The read strobe is a one-cycle pulse raised on every entry to FETCH.
            mem_rd_en <= 1'b0;

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state      <= S_FETCH;
                        idx        <= '0;
                        sample_cnt <= '0;
                        mem_rd_en  <= 1'b1;
                        busy       <= 1'b1;
                        feed_done  <= 1'b0;
`ifdef OPTI_FEEDER_FLUSH_EN
                        flush_cnt  <= 10'd0;
                        flushing   <= 1'b0;
`endif
                    end
                end

                S_FETCH: begin
                    state <= S_WAIT;
                end

                // RAM data for the strobe issued in FETCH is on mem_rd_data now.
                S_WAIT: begin
                    data_in       <= mem_rd_data;
                    data_in_valid <= 1'b1;
                    state         <= S_PRESENT;
                end

                S_PRESENT: begin
                    if (xfer) begin
                        data_in_valid <= 1'b0;
                        sample_cnt    <= sample_cnt + 1'b1;
                        if (idx == LAST_IDX) begin
`ifdef OPTI_FEEDER_FLUSH_EN
                            flushing <= 1'b1;
                            if (HAS_GAP) begin
                                state <= S_GAP;
                            end else begin
                                state         <= S_FLUSH;
                                data_in       <= '0;
                                data_in_valid <= 1'b1;
                            end
`else
                            state <= S_DRAIN;
`endif
                        end else begin
                            idx <= idx + 1'b1;
                            if (HAS_GAP) begin
                                state <= S_GAP;
                            end else begin
                                state     <= S_FETCH;
                                mem_rd_en <= 1'b1;
                            end
                        end
                    end
                end

                S_GAP: begin
                    if (gap_expired) begin
`ifdef OPTI_FEEDER_FLUSH_EN
                        if (flushing) begin
                            state         <= S_FLUSH;
                            data_in       <= '0;
                            data_in_valid <= 1'b1;
                        end else begin
                            state     <= S_FETCH;
                            mem_rd_en <= 1'b1;
                        end
`else
                        state     <= S_FETCH;
                        mem_rd_en <= 1'b1;
`endif
                    end
                end

`ifdef OPTI_FEEDER_FLUSH_EN
                // Zero samples need no RAM access; with no gap, valid stays high
                // and the next zero sample follows on the very next cycle.
                S_FLUSH: begin
                    if (xfer) begin
                        flush_cnt <= flush_cnt + 10'd1;
                        if (flush_cnt == FLUSH_LAST) begin
                            state         <= S_DRAIN;
                            data_in_valid <= 1'b0;
                        end else if (HAS_GAP) begin
                            state         <= S_GAP;
                            data_in_valid <= 1'b0;
                        end
                    end
                end
`endif

                // filter_done is ignored everywhere else, so a done that coincides
                // with the last transfer still lands here first.
                S_DRAIN: begin
                    if (filter_done) begin
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        feed_done <= 1'b1;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
